// File: rtl/tdm_demux.sv
// ============================================================================
// Module   : tdm_demux
// Brief    : TDM slot demultiplexer; frame-atomic parallel channel output.
//            Optional error counter port enabled by TDM_DEMUX_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din_i,
    input  logic                     din_valid_i,
    input  logic                     frame_sync_i,
    output logic [NUM_CH*DATA_W-1:0] ch_data_o,
    output logic                     frame_done_o,
    output logic                     locked_o,
    output logic                     sync_err_o
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]               err_cnt_o
`endif
);

    typedef enum logic [0:0] {
        S_HUNT = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_SLOT = CNT_W'(NUM_CH - 1);

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [DATA_W-1:0]          staging_q [NUM_CH-1];
    logic [NUM_CH*DATA_W-1:0]   ch_data_q;
    logic                       frame_done_q;
    logic                       sync_err_q;
    logic                       locked_q;
    logic                       w_sync_err;

    // Framing violation: sync off slot 0 (early) or slot 0 arriving without sync.
    assign w_sync_err = din_valid_i && (state_q == S_LOCK) &&
                        (frame_sync_i ? (cnt_q != '0) : (cnt_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HUNT;
            cnt_q        <= '0;
            for (int k = 0; k < NUM_CH - 1; k++) begin
                staging_q[k] <= '0;
            end
            ch_data_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sync_err_q   <= w_sync_err;
            if (din_valid_i) begin
                case (state_q)
                    S_HUNT: begin
                        if (frame_sync_i) begin
                            staging_q[0] <= din_i;
                            cnt_q        <= CNT_W'(1);
                            state_q      <= S_LOCK;
                            locked_q     <= 1'b1;
                        end
                    end
                    S_LOCK: begin
                        if (frame_sync_i) begin
                            // Normal frame start or early resync: both restart at slot 0.
                            staging_q[0] <= din_i;
                            cnt_q        <= CNT_W'(1);
                        end else if (cnt_q == '0) begin
                            state_q  <= S_HUNT;
                            locked_q <= 1'b0;
                        end else if (cnt_q == c_LAST_SLOT) begin
                            for (int k = 0; k < NUM_CH - 1; k++) begin
                                ch_data_q[k*DATA_W +: DATA_W] <= staging_q[k];
                            end
                            ch_data_q[(NUM_CH-1)*DATA_W +: DATA_W] <= din_i;
                            frame_done_q <= 1'b1;
                            cnt_q        <= '0;
                        end else begin
                            for (int k = 1; k < NUM_CH - 1; k++) begin
                                if (cnt_q == CNT_W'(k)) begin
                                    staging_q[k] <= din_i;
                                end
                            end
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= S_HUNT;
                        locked_q <= 1'b0;
                        cnt_q    <= '0;
                    end
                endcase
            end
        end
    end

    assign ch_data_o    = ch_data_q;
    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;
    assign locked_o     = locked_q;

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (w_sync_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
// Module   : tb_tdm_demux
// Brief    : Self-checking bench for tdm_demux against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int W      = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] din_i = '0;
    logic              din_valid_i = 1'b0;
    logic              frame_sync_i = 1'b0;
    logic [W-1:0]      ch_data_o;
    logic              frame_done_o;
    logic              locked_o;
    logic              sync_err_o;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0]        err_cnt_o;
`endif

    tdm_demux #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_i        (din_i),
        .din_valid_i  (din_valid_i),
        .frame_sync_i (frame_sync_i),
        .ch_data_o    (ch_data_o),
        .frame_done_o (frame_done_o),
        .locked_o     (locked_o),
        .sync_err_o   (sync_err_o)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_cnt_o    (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words of the frame in progress, link lock flag, last good frame.
    bit                m_lock;
    logic [DATA_W-1:0] m_slots [$];
    logic [W-1:0]      m_ch;
    bit                m_done;
    bit                m_err;
    int                m_errs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_slots.delete();
        m_ch   = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_errs = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [DATA_W-1:0] d);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (v) begin
            if (!m_lock) begin
                if (s) begin
                    m_slots = {d};
                    m_lock  = 1'b1;
                end
            end else if (s) begin
                if (m_slots.size() != 0) m_err = 1'b1;
                m_slots = {d};
            end else if (m_slots.size() == 0) begin
                m_err  = 1'b1;
                m_lock = 1'b0;
            end else begin
                m_slots.push_back(d);
                if (m_slots.size() == NUM_CH) begin
                    for (int i = 0; i < NUM_CH; i++) m_ch[i*DATA_W +: DATA_W] = m_slots[i];
                    m_done = 1'b1;
                    m_slots.delete();
                end
            end
        end
        if (m_err) m_errs++;
    endtask

    task automatic check_outputs();
        check("ch_data", 64'(ch_data_o), 64'(m_ch));
        check("frame_done", 64'(frame_done_o), 64'(m_done));
        check("sync_err", 64'(sync_err_o), 64'(m_err));
        check("locked", 64'(locked_o), 64'(m_lock));
`ifdef TDM_DEMUX_ERR_CNT_EN
        check("err_cnt", 64'(err_cnt_o), (m_errs > 255) ? 64'd255 : 64'(m_errs));
`endif
    endtask

    task automatic drive(input bit v, input bit s, input logic [DATA_W-1:0] d);
        @(negedge clk);
        din_valid_i  = v;
        frame_sync_i = s;
        din_i        = d;
        model_step(v, s, d);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bit   rs;
        bit   rv;
        logic [DATA_W-1:0] rd;

        // Reset then idle
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Clean frame
        drive(1, 1, 8'hA0); drive(1, 0, 8'hA1); drive(1, 0, 8'hA2); drive(1, 0, 8'hA3);
        check("clean_frame", 64'(ch_data_o), 64'h0000_0000_A3A2_A1A0);
        idle(1);

        // Gapped frame
        drive(1, 1, 8'h11); idle(3); drive(1, 0, 8'h22); idle(1);
        drive(1, 0, 8'h33); drive(1, 0, 8'h44);
        check("gapped_frame", 64'(ch_data_o), 64'h0000_0000_4433_2211);
        idle(2);

        // Early sync
        drive(1, 1, 8'h10); drive(1, 0, 8'h20); drive(1, 1, 8'h30);
        drive(1, 0, 8'h40); drive(1, 0, 8'h50); drive(1, 0, 8'h60);
        check("early_sync", 64'(ch_data_o), 64'h0000_0000_6050_4030);

        // Missing sync, then non-sync words ignored until a sync word
        drive(1, 0, 8'h55); drive(1, 0, 8'h66); drive(1, 0, 8'h77); idle(1);
        check("missing_sync_hold", 64'(ch_data_o), 64'h0000_0000_6050_4030);
        drive(1, 1, 8'h01); drive(1, 0, 8'h02); drive(1, 0, 8'h03); drive(1, 0, 8'h04);

`ifdef TDM_DEMUX_ERR_CNT_EN
        // Repeated sync words: each one after the first is an early sync
        for (int i = 0; i < 301; i++) drive(1, 1, 8'(i));
        check("err_cnt_sat", 64'(err_cnt_o), 64'hFF);
        drive(1, 0, 8'h00); drive(1, 0, 8'h00); drive(1, 0, 8'h00);
`endif

        // Randomised traffic, biased toward correct framing with sporadic violations
        for (int i = 0; i < 2000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rs = (m_slots.size() == 0) ? ($urandom_range(0, 7) != 0)
                                       : ($urandom_range(0, 15) == 0);
            rd = DATA_W'($urandom_range(0, 255));
            drive(rv, rs, rd);
        end

        // Reset mid-frame: outputs clear without a clock edge
        drive(1, 1, 8'hC0); drive(1, 0, 8'hC1); drive(1, 0, 8'hC2); drive(1, 0, 8'hC3);
        drive(1, 1, 8'hD0); drive(1, 0, 8'hD1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        din_valid_i = 1'b0;
        drive(1, 0, 8'hD2); drive(1, 0, 8'hD3);
        drive(1, 1, 8'hB0); drive(1, 0, 8'hB1); drive(1, 0, 8'hB2); drive(1, 0, 8'hB3);
        check("post_reset_frame", 64'(ch_data_o), 64'h0000_0000_B3B2_B1B0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer; the receive-side counterpart of the team's 2:1/N:1 mux blocks.
- Accepts a serial stream of DATA_W-bit slot words with a frame-sync marker on slot 0.
- Steers each word to its channel and presents all NUM_CH channels together, updated atomically once per complete frame.
- Sits between a serial/TDM link front end and parallel per-channel logic (LED/7-seg drivers, etc.) on Mimas V2.

Parameters:
- DATA_W, 8, bits per slot word.
- NUM_CH, 4, slots per frame; legal range 2..16.
- CNT_W, 4, slot counter width; must satisfy 2**CNT_W >= NUM_CH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_W  slot word.
- din_valid  input  1  din is valid this cycle; one slot consumed per valid cycle.
- frame_sync  input  1  qualifies din as slot 0; ignored when din_valid=0.
- ch_data  output  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]; registered.
- frame_done  output  1  one-cycle pulse when ch_data updates.
- locked  output  1  1 while in LOCK state.
- sync_err  output  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State HUNT; slot counter 0; staging registers 0.
  - ch_data=0, frame_done=0, locked=0, sync_err=0.
- States: HUNT, LOCK.
- HUNT:
  - din_valid=1 with frame_sync=0: word discarded, no error.
  - din_valid=1 with frame_sync=1: din stored to staging[0], counter=1, go to LOCK.
- LOCK, on each din_valid=1 cycle with counter=c:
  - c!=0, frame_sync=0: store din to staging[c], counter=c+1.
  - c==NUM_CH-1, frame_sync=0: at the same edge, ch_data <= {din, staging[NUM_CH-2..0]}, frame_done=1 for the following cycle, counter wraps to 0.
  - c==0, frame_sync=1: start of the next frame; store to staging[0], counter=1.
  - c==0, frame_sync=0: missing sync. sync_err pulse, word discarded, go to HUNT.
  - c!=0, frame_sync=1: early sync. sync_err pulse, partial frame discarded (ch_data unchanged), din stored as slot 0, counter=1, stay in LOCK.
- din_valid=0: no state change, counter holds. Gaps of any length are allowed mid-frame.
- Latency: the last slot is sampled at edge N; ch_data and frame_done are valid after edge N. frame_done deasserts after edge N+1 unless another frame completes, which is not possible for NUM_CH>=2.
- ch_data holds its value between frames and on all errors. Only a complete, correctly framed frame updates it.
- locked is a registered copy of the state (1 in LOCK). Back-to-back frames with no idle cycles are supported.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: TDM_DEMUX_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt [7:0].
  - Increments on each sync_err pulse and saturates at 8'hFF.
  - Cleared only by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (DATA_W=8, NUM_CH=4):
- Reset then idle: rst_n=0 for 3 cycles, then idle → ch_data=0, locked=0, frame_done=0, sync_err=0.
- Clean frame: valids A0(sync),A1,A2,A3 on consecutive cycles → after 4th edge ch_data=32'hA3A2A1A0, frame_done high exactly 1 cycle, locked=1.
- Gapped frame: 11(sync),idle×3,22,idle,33,44 → ch_data=32'h44332211, a single frame_done pulse.
- Early sync: 10(sync),20,30(sync),40,50,60 → sync_err pulse at the 30 word; ch_data=32'h60504030; the 10/20 partial frame is never visible.
- Missing sync: a complete frame, then 55 with frame_sync=0 → sync_err pulse, locked=0, ch_data unchanged. Subsequent non-sync words are ignored until the next sync word. With TDM_DEMUX_ERR_CNT_EN, err_cnt increments by 1; 300 errors give err_cnt=8'hFF.
- Reset mid-frame: rst_n low after 2 words → outputs 0 immediately, even with no clock edge. After release, a full frame (sync first) is required to update ch_data.
